// File: rtl/sha256_wsched_pkg.sv
// Shared constants, state encoding and sigma helpers for the SHA-256 message schedule.
package sha256_wsched_pkg;

  localparam int ROUNDS_DEF = 64;

  localparam int unsigned S0_R1 = 7;
  localparam int unsigned S0_R2 = 18;
  localparam int unsigned S0_SH = 3;
  localparam int unsigned S1_R1 = 17;
  localparam int unsigned S1_R2 = 19;
  localparam int unsigned S1_SH = 10;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_EXPAND = 1'b1
  } wsched_state_t;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr32(x, S0_R1) ^ rotr32(x, S0_R2) ^ (x >> S0_SH);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr32(x, S1_R1) ^ rotr32(x, S1_R2) ^ (x >> S1_SH);
  endfunction

endpackage

// File: rtl/sha256_wsched_add4.sv
// Combinational sigma1(a) + b + sigma0(c) + d, modulo 2^32.
// Synthesis path reduces the four operands with two carry-save layers before one carry-propagate add.
module sha256_wsched_add4
  import sha256_wsched_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  output logic [31:0] o_sum
);

  logic [31:0] w_s1;
  logic [31:0] w_s0;

  assign w_s1 = sigma1(i_a);
  assign w_s0 = sigma0(i_c);

`ifdef SIMULATION
  assign o_sum = w_s1 + i_b + w_s0 + i_d;
`else
  logic [31:0] w_sum1;
  logic [30:0] w_maj1;
  logic [31:0] w_car1;
  logic [31:0] w_sum2;
  logic [30:0] w_maj2;
  logic [31:0] w_car2;

  // Carries shifted out of bit 31 are dropped, which is exactly the mod 2^32 wrap.
  assign w_sum1 = w_s1 ^ i_b ^ w_s0;
  assign w_maj1 = (w_s1[30:0] & i_b[30:0]) | (w_s1[30:0] & w_s0[30:0]) | (i_b[30:0] & w_s0[30:0]);
  assign w_car1 = {w_maj1, 1'b0};

  assign w_sum2 = w_sum1 ^ w_car1 ^ i_d;
  assign w_maj2 = (w_sum1[30:0] & w_car1[30:0]) | (w_sum1[30:0] & i_d[30:0]) | (w_car1[30:0] & i_d[30:0]);
  assign w_car2 = {w_maj2, 1'b0};

  assign o_sum = w_sum2 + w_car2;
`endif

endmodule

// File: rtl/sha256_wsched.sv
// SHA-256 message schedule: passes W[0..15] through, expands W[16..ROUNDS-1] from a 16-word shift buffer.
// Single registered output stage; advances when the output is empty or being consumed.
module sha256_wsched
  import sha256_wsched_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [5:0]       out_idx
);

  localparam logic [5:0] LAST_IDX  = 6'(ROUNDS - 1);
  localparam logic [5:0] LOAD_LAST = 6'd15;

  wsched_state_t    r_state;
  wsched_state_t    w_state_nxt;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_buf [16];
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_word;
  logic             w_adv;
  logic             w_shift;

  // r_buf[0] is W[t-16], r_buf[15] is W[t-1].
  sha256_wsched_add4 u_add4 (
    .i_a   (r_buf[14]),
    .i_b   (r_buf[9]),
    .i_c   (r_buf[1]),
    .i_d   (r_buf[0]),
    .o_sum (w_sum)
  );

  assign w_adv = !out_valid || out_ready;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_shift     = 1'b0;
    w_word      = w_sum;
    case (r_state)
      ST_LOAD: begin
        in_ready = w_adv;
        w_shift  = w_adv && in_valid;
        w_word   = din;
        if (w_shift && (r_cnt == LOAD_LAST)) w_state_nxt = ST_EXPAND;
      end
      ST_EXPAND: begin
        w_shift = w_adv;
        if (w_shift && (r_cnt == LAST_IDX)) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state   <= ST_LOAD;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      dout      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_shift) begin
        dout      <= w_word;
        out_idx   <= r_cnt;
        out_last  <= (r_cnt == LAST_IDX);
        out_valid <= 1'b1;
        r_cnt     <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 6'd1;
      end else if (w_adv) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge CLK) begin
    if (w_shift) begin
      for (int i = 0; i < 15; i++) r_buf[i] <= r_buf[i+1];
      r_buf[15] <= w_word;
    end
  end

endmodule

// File: tb/tb_sha256_wsched.sv
// Directed bench for sha256_wsched: known-answer blocks, backpressure, gaps, back-to-back and mid-block reset.
module tb_sha256_wsched;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [5:0]  out_idx;

  sha256_wsched dut (
    .CLK       (CLK),
    .rst       (rst),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_idx   (out_idx)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] blk[16];
  logic [31:0] mdl[64];
  logic [31:0] got[64];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          hs0_cyc = 0;
  int          hs63_cyc = 0;
  bit          rnd_ready = 0;
  bit          b2b_chk = 0;
  bit          seen30 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int t = 0; t < 16; t++) mdl[t] = blk[t];
    for (int t = 16; t < 64; t++)
      mdl[t] = m_s1(mdl[t-2]) + mdl[t-7] + m_s0(mdl[t-15]) + mdl[t-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_ones();
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
  endtask

  task automatic clear_got();
    for (int i = 0; i < 64; i++) got[i] = 32'h0;
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Every valid cycle must show the head of the expected stream, whether or not it is consumed.
  always @(negedge CLK) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'd1, 32'd0);
      end else begin
        chk("dout", dout, exp_q[0].w);
        chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
        chk("out_last", 32'(out_last), 32'(exp_q[0].last));
        if (out_ready) begin
          got[out_idx] = dout;
          if (out_idx == 6'd0) begin
            hs0_cyc = cyc;
            if (b2b_chk) begin
              chk("b2b_gap", 32'(cyc - hs63_cyc), 32'd1);
              b2b_chk = 0;
            end
          end
          if (out_idx == 6'd63) hs63_cyc = cyc;
          if (out_idx == 6'd30) seen30 = 1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_block(input bit gap);
    int guard;
    bit acc;
    build_model();
    for (int t = 0; t < 64; t++) exp_q.push_back({mdl[t], 6'(t), 1'(t == 63)});
    for (int i = 0; i < 16; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
      end
      in_valid = 1'b1;
      din      = blk[i];
      acc      = 0;
      guard    = 0;
      while (!acc && guard < 1000) begin
        @(negedge CLK);
        if (gap && i > 0 && guard == 0) chk("gap_bubble", 32'(out_valid), 32'd0);
        acc = in_ready;
        @(posedge CLK);
        #1;
        guard++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int guard;
    in_valid = 1'b0;
    din      = 32'h0;
    clear_got();

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1;

    // "abc" block, no backpressure
    set_abc();
    send_block(0);
    drain();
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000F0000);
    chk("abc_w63", got[63], 32'h12B1EDEB);
    chk("abc_span", 32'(hs63_cyc - hs0_cyc), 32'd63);

    // same block under random backpressure
    clear_got();
    rnd_ready = 1;
    set_abc();
    send_block(0);
    drain();
    rnd_ready = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rnd_w17", got[17], 32'h000F0000);
    chk("rnd_w63", got[63], 32'h12B1EDEB);

    // back-to-back blocks with in_valid held high
    clear_got();
    set_abc();
    send_block(0);
    b2b_chk = 1;
    set_ones();
    send_block(0);
    drain();
    chk("b2b_checked", 32'(b2b_chk), 32'd0);
    chk("b2b_ones_w16", got[16], 32'h203FFFFC);

    // gap every other input cycle
    clear_got();
    set_abc();
    send_block(1);
    drain();
    chk("gap_w16", got[16], 32'h61626380);
    chk("gap_w63", got[63], 32'h12B1EDEB);

    // reset in the middle of a block
    seen30 = 0;
    set_abc();
    send_block(0);
    guard = 0;
    while (!seen30 && guard < 200) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (!seen30) chk("seen30_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_dout", dout, 32'd0);
    chk("arst_out_idx", 32'(out_idx), 32'd0);
    chk("arst_out_last", 32'(out_last), 32'd0);
    exp_q.delete();
    @(posedge CLK);
    #1;
    rst = 1'b0;
    clear_got();
    set_ones();
    send_block(0);
    drain();
    chk("post_rst_w0", got[0], 32'hFFFFFFFF);
    chk("post_rst_w16", got[16], 32'h203FFFFC);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
